// File: rtl/dma_fifo_drain_pkg.sv
// Shared types for the DMA FIFO drain engine: FSM state encoding.
package dma_fifo_drain_pkg;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_POP   = 3'd1,
      S_LATCH = 3'd2,
      S_WRITE = 3'd3,
      S_CHECK = 3'd4,
      S_FIN   = 3'd5
   } state_t;

endpackage

// File: rtl/dma_fifo_drain.sv
// Drains the one-shot 512-byte DMA FIFO into sequential memory addresses over a
// req/ack write bus, sector by sector, re-arming the FIFO between sectors.
module dma_fifo_drain
   import dma_fifo_drain_pkg::*;
#(
   parameter int ADDR_W = 22,
   parameter int SEC_W  = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              abort,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [SEC_W-1:0]  sec_cnt,
   output logic              busy,
   output logic              done,
   input  logic              fifo_empty,
   input  logic              fifo_rdone,
   input  logic [7:0]        fifo_rd,
   output logic              fifo_rd_stb,
   output logic              fifo_init,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_wd,
   input  logic              mem_ack
);

   state_t            state, state_d;
   logic              busy_d, done_d, stb_d, init_d, req_d;
   logic [ADDR_W-1:0] addr_d;
   logic [7:0]        wd_d;
   logic [SEC_W-1:0]  sec_left, sec_left_d;
   logic              abort_q, abort_q_d;
   logic              abort_now;

   assign abort_now = abort_q | abort;

   // NOTE: every registered signal gets a default at the top of always_comb, so no
   // path through the case statement can leave one unassigned and infer a latch.
   always_comb begin
      state_d    = state;
      busy_d     = busy;
      done_d     = 1'b0;
      stb_d      = 1'b0;
      init_d     = 1'b0;
      req_d      = mem_req;
      addr_d     = mem_addr;
      wd_d       = mem_wd;
      sec_left_d = sec_left;
      abort_q_d  = busy & abort_now;

      // The pop strobe is registered, so it is decided one cycle early: it becomes
      // visible in POP and the popped byte is on fifo_rd during LATCH.
      unique case (state)
         S_IDLE: begin
            if (start) begin
               if (sec_cnt != '0) begin
                  busy_d     = 1'b1;
                  addr_d     = base_addr;
                  sec_left_d = sec_cnt;
                  stb_d      = ~fifo_empty;
                  state_d    = S_POP;
               end else begin
                  done_d = 1'b1;
               end
            end
         end
         S_POP: begin
            if (fifo_rd_stb) begin
               state_d = S_LATCH;
            end else if (abort_now) begin
               init_d  = 1'b1;
               state_d = S_FIN;
            end else if (!fifo_empty && !fifo_init) begin
               stb_d = 1'b1;
            end
         end
         S_LATCH: begin
            wd_d    = fifo_rd;
            req_d   = 1'b1;
            state_d = S_WRITE;
         end
         S_WRITE: begin
            if (mem_ack) begin
               req_d   = 1'b0;
               addr_d  = mem_addr + 1'b1;
               state_d = S_CHECK;
            end
         end
         S_CHECK: begin
            if (abort_now) begin
               init_d  = 1'b1;
               state_d = S_FIN;
            end else if (fifo_rdone) begin
               // Fresh sector: the FIFO is being cleared, so no early strobe here.
               init_d     = 1'b1;
               sec_left_d = sec_left - 1'b1;
               state_d    = (sec_left == SEC_W'(1)) ? S_FIN : S_POP;
            end else begin
               stb_d   = ~fifo_empty;
               state_d = S_POP;
            end
         end
         S_FIN: begin
            busy_d    = 1'b0;
            done_d    = 1'b1;
            abort_q_d = 1'b0;
            state_d   = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only, so every flop samples
   // the pre-edge value of every other flop regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         busy        <= 1'b0;
         done        <= 1'b0;
         fifo_rd_stb <= 1'b0;
         fifo_init   <= 1'b0;
         mem_req     <= 1'b0;
         mem_addr    <= '0;
         mem_wd      <= '0;
         sec_left    <= '0;
         abort_q     <= 1'b0;
      end else begin
         state       <= state_d;
         busy        <= busy_d;
         done        <= done_d;
         fifo_rd_stb <= stb_d;
         fifo_init   <= init_d;
         mem_req     <= req_d;
         mem_addr    <= addr_d;
         mem_wd      <= wd_d;
         sec_left    <= sec_left_d;
         abort_q     <= abort_q_d;
      end
   end

endmodule

// File: tb/tb_dma_fifo_drain.sv
// Self-checking bench for dma_fifo_drain: FIFO + memory responder models, vector table
// of whole runs, and hand sequences for abort, zero-count start and mid-run reset.
module tb_dma_fifo_drain;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic [21:0] base_addr = '0;
   logic [7:0]  sec_cnt = '0;
   logic        busy, done, fifo_empty, fifo_rdone, fifo_rd_stb, fifo_init, mem_req;
   logic [7:0]  fifo_rd, mem_wd;
   logic [21:0] mem_addr;
   logic        mem_ack = 1'b0;

   always #5 clk = ~clk;

   dma_fifo_drain #(.ADDR_W(22), .SEC_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .base_addr(base_addr), .sec_cnt(sec_cnt), .busy(busy), .done(done),
      .fifo_empty(fifo_empty), .fifo_rdone(fifo_rdone), .fifo_rd(fifo_rd),
      .fifo_rd_stb(fifo_rd_stb), .fifo_init(fifo_init), .mem_req(mem_req),
      .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_ack(mem_ack)
   );

   // ---------------- FIFO + producer model ----------------
   logic [7:0] fmem   [512];
   logic [7:0] stream [1536];      // bytes the producer feeds in this run, in order
   int wcnt, rcnt, gap_cnt, ptot;
   bit prod_en = 1'b0;
   int prod_gap = 0, prod_limit = 0, prod_base = 0;

   assign fifo_empty = (wcnt == rcnt);
   assign fifo_rdone = (rcnt == 512);

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wcnt <= 0; rcnt <= 0; gap_cnt <= 0; fifo_rd <= '0;
      end else if (fifo_init) begin
         wcnt <= 0; rcnt <= 0;
      end else begin
         if (fifo_rd_stb && rcnt != wcnt) begin
            fifo_rd <= fmem[rcnt[8:0]];
            rcnt    <= rcnt + 1;
         end
         if (gap_cnt > 0) gap_cnt <= gap_cnt - 1;
         else if (prod_en && wcnt < 512 && (ptot - prod_base) < prod_limit) begin
            fmem[wcnt[8:0]] <= stream[ptot - prod_base];
            wcnt    <= wcnt + 1;
            ptot    <= ptot + 1;
            gap_cnt <= prod_gap;
         end
      end
   end

   // ---------------- memory responder + monitors ----------------
   typedef struct packed { logic [21:0] addr; logic [7:0] data; } wr_t;
   wr_t wr_q [$];
   int ack_lo = 0, ack_hi = 0, wait_cnt = 0, ack_dly = 0;
   int stb_viol = 0, stab_viol = 0, init_cnt = 0, done_cnt = 0, busy_cyc = 0;
   logic [21:0] hold_addr;
   logic [7:0]  hold_wd;

   always @(negedge clk) begin
      if (!rst_n) begin
         mem_ack  = 1'b0;
         wait_cnt = 0;
      end else begin
         if (fifo_rd_stb && fifo_empty) stb_viol++;
         if (fifo_init) init_cnt++;
         if (done) done_cnt++;
         if (busy) busy_cyc++;
         if (mem_ack) mem_ack = 1'b0;
         else if (mem_req) begin
            if (wait_cnt == 0) begin
               hold_addr = mem_addr;
               hold_wd   = mem_wd;
               ack_dly   = int'($urandom_range(ack_hi, ack_lo));
            end else if (mem_addr != hold_addr || mem_wd != hold_wd) stab_viol++;
            if (wait_cnt >= ack_dly) begin
               mem_ack = 1'b1;
               wr_q.push_back({mem_addr, mem_wd});
               wait_cnt = 0;
            end else wait_cnt++;
         end
      end
   end

   // ---------------- checking ----------------
   int n_pass = 0, n_total = 0;
   int w0, i0, d0, sv0, tv0, b0;

   task automatic check(input string name, input longint act, input longint exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
   endtask

   task automatic snap();
      w0 = wr_q.size(); i0 = init_cnt; d0 = done_cnt;
      sv0 = stb_viol; tv0 = stab_viol; b0 = busy_cyc;
   endtask

   // Reference: write k goes to base+k (mod 2**22) carrying the k-th produced byte.
   task automatic score(input string tag, input logic [21:0] base, input int n_exp);
      int bad = -1;
      int n_got = wr_q.size() - w0;
      check({tag, "_writes"}, n_got, n_exp);
      for (int k = 0; k < n_got && k < n_exp; k++) begin
         logic [21:0] ea = base + 22'(k);
         if (bad < 0 && (wr_q[w0 + k].addr != ea || wr_q[w0 + k].data != stream[k])) bad = k;
      end
      check({tag, "_first_bad"}, bad, -1);
   endtask

   typedef struct {
      logic [21:0] base;
      int cnt, ack_lo, ack_hi, gap;
      bit prefill, pattern;
      int exp_writes, exp_inits;
   } vec_t;
   vec_t vecs [5];

   task automatic setup_run(input vec_t v, input int limit);
      prod_en = 1'b0;
      for (int k = 0; k < 1536; k++) stream[k] = v.pattern ? 8'(k) : 8'($urandom);
      prod_base = ptot; prod_limit = limit; prod_gap = v.gap;
      ack_lo = v.ack_lo; ack_hi = v.ack_hi;
      prod_en = 1'b1;
      if (v.prefill) for (int c = 0; c < 1000 && wcnt < 512; c++) @(negedge clk);
      snap();
   endtask

   task automatic pulse_start(input logic [21:0] base, input int cnt);
      @(negedge clk);
      start = 1'b1; base_addr = base; sec_cnt = 8'(cnt);
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int budget);
      int c = 0;
      while (done_cnt == d0 && c < budget) begin @(negedge clk); c++; end
      if (done_cnt == d0) check({tag, "_timeout"}, 0, 1);
      repeat (5) @(negedge clk);
   endtask

   task automatic wait_writes(input int n, input bit need_req, input int budget);
      for (int c = 0; c < budget; c++) begin
         @(negedge clk);
         if (wr_q.size() - w0 >= n && (!need_req || mem_req)) break;
      end
   endtask

   task automatic run_vec(input string tag, input vec_t v);
      setup_run(v, v.cnt * 512);
      pulse_start(v.base, v.cnt);
      wait_done(tag, 30000);
      prod_en = 1'b0;
      score(tag, v.base, v.exp_writes);
      check({tag, "_inits"}, init_cnt - i0, v.exp_inits);
      check({tag, "_dones"}, done_cnt - d0, 1);
      check({tag, "_stb_empty"}, stb_viol - sv0, 0);
      check({tag, "_stable"}, stab_viol - tv0, 0);
      check({tag, "_busy_end"}, busy, 0);
   endtask

   initial begin
      vecs[0] = '{22'h001000, 1, 0, 0, 0,  1'b1, 1'b1, 512,  1};  // prefilled ramp
      vecs[1] = '{22'h005A5A, 1, 0, 0, 19, 1'b0, 1'b0, 512,  1};  // slow producer
      vecs[2] = '{22'h020000, 3, 0, 5, 0,  1'b0, 1'b0, 1536, 3};  // 3 sectors, slow ack
      vecs[3] = '{22'h3FFFFE, 1, 0, 2, 0,  1'b1, 1'b1, 512,  1};  // address wrap
      vecs[4] = '{22'($urandom), 2, 0, 3, int'($urandom_range(4, 0)), 1'b0, 1'b0, 1024, 2};

      repeat (3) @(negedge clk);
      check("reset_outputs", {busy, done, fifo_rd_stb, fifo_init, mem_req, mem_addr, mem_wd}, 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      for (int i = 0; i < 5; i++) begin
         run_vec($sformatf("vec%0d", i), vecs[i]);
         if (i == 0) check("vec0_last", wr_q[w0 + 511], {22'h0011FF, 8'hFF});
         if (i == 3) begin
            check("wrap_top", wr_q[w0 + 1].addr, 22'h3FFFFF);
            check("wrap_zero", wr_q[w0 + 2].addr, 22'h000000);
         end
      end

      // Abort while byte 100 is waiting for ack; a stray start mid-run must be ignored.
      setup_run('{22'h000400, 2, 3, 3, 0, 1'b1, 1'b0, 0, 0}, 1024);
      pulse_start(22'h000400, 2);
      wait_writes(50, 1'b0, 2000);
      pulse_start(22'h003000, 5);
      wait_writes(100, 1'b1, 2000);
      abort = 1'b1; prod_en = 1'b0;
      @(negedge clk);
      abort = 1'b0;
      wait_done("abort", 200);
      repeat (40) @(negedge clk);
      score("abort", 22'h000400, 101);
      check("abort_inits", init_cnt - i0, 1);
      check("abort_dones", done_cnt - d0, 1);
      check("abort_req_idle", mem_req, 0);
      check("abort_busy_end", busy, 0);

      // Zero-sector start: done on the next cycle, nothing else.
      snap();
      pulse_start(22'h001234, 0);
      check("zero_done_now", done, 1);
      repeat (10) @(negedge clk);
      check("zero_dones", done_cnt - d0, 1);
      check("zero_writes", wr_q.size() - w0, 0);
      check("zero_busy", busy_cyc - b0, 0);

      // Abort while POP is starved on an empty FIFO after 5 bytes.
      setup_run('{22'h000800, 1, 0, 1, 0, 1'b0, 1'b0, 0, 0}, 5);
      pulse_start(22'h000800, 1);
      wait_writes(5, 1'b0, 500);
      repeat (10) @(negedge clk);
      check("starve_busy", busy, 1);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      wait_done("starve", 50);
      prod_en = 1'b0;
      score("starve", 22'h000800, 5);
      check("starve_inits", init_cnt - i0, 1);
      check("starve_dones", done_cnt - d0, 1);
      check("starve_stb_empty", stb_viol - sv0, 0);

      // Asynchronous reset mid-sector, then a normal run.
      setup_run('{22'h010000, 2, 0, 2, 0, 1'b1, 1'b0, 0, 0}, 1024);
      pulse_start(22'h010000, 2);
      wait_writes(200, 1'b0, 3000);
      prod_en = 1'b0;
      #2 rst_n = 1'b0;
      #1 check("rst_async", {busy, done, fifo_rd_stb, fifo_init, mem_req, mem_addr, mem_wd}, 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      check("rst_no_done", done_cnt - d0, 0);
      run_vec("post_rst", vecs[0]);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
